// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NAND)
// among N_REQ requesters; each grant runs a fixed IDLE->EXEC->RESP transaction.
module gate_unit_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  input  logic [N_REQ*2-1:0]     opsel,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  logic [1:0]       state, state_d;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0] owner, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [N_REQ-1:0] grant_d, done_d;
  logic [WIDTH-1:0] result_d;
  logic             busy_d;

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] scan_idx;
  logic [WIDTH-1:0] a_sel, b_sel, f_val;
  logic [1:0]       op_sel;

  // Round-robin search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = PTR_W'((32'(rr_ptr) + i) % N_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    op_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == win_idx) begin
        a_sel  = op_a[i*WIDTH +: WIDTH];
        b_sel  = op_b[i*WIDTH +: WIDTH];
        op_sel = opsel[i*2 +: 2];
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_AND:  f_val = a_q & b_q;
      OP_OR:   f_val = a_q | b_q;
      OP_XOR:  f_val = a_q ^ b_q;
      default: f_val = ~(a_q & b_q);
    endcase
  end

  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    owner_d  = owner;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    grant_d  = grant;
    done_d   = '0;
    result_d = result;
    case (state)
      ST_IDLE: begin
        grant_d = '0;
        if (win_found) begin
          owner_d = win_idx;
          a_d     = a_sel;
          b_d     = b_sel;
          op_d    = op_sel;
          grant_d = N_REQ'(1) << win_idx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = f_val;
        done_d   = N_REQ'(1) << owner;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        grant_d  = '0;
        rr_ptr_d = (32'(owner) == N_REQ - 1) ? '0 : owner + PTR_W'(1);
        state_d  = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      grant  <= '0;
      done   <= '0;
      result <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      rr_ptr <= rr_ptr_d;
      owner  <= owner_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      grant  <= grant_d;
      done   <= done_d;
      result <= result_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter: reset, single op, function sweep,
// round-robin fairness, input sampling/abort and mid-transaction reset.
module tb_gate_unit_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [7:0]  opsel;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  gate_unit_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .opsel(opsel), .grant(grant), .done(done), .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op);
    op_a[i*8 +: 8]  = a;
    op_b[i*8 +: 8]  = b;
    opsel[i*2 +: 2] = op;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    op_a  = '0;
    op_b  = '0;
    opsel = '0;
    tick();
    tick();
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done got=%b exp=0000", done); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got=%h exp=00", result); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got=%b exp=0001", grant); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_single_op();
    set_slot(2, 8'hF0, 8'h3C, 2'b00);
    req = 4'b0100;
    tick();
    req = '0;
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant got=%b exp=0100", grant); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL single_done_early got=%b exp=0000", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy1 got=%b exp=1", busy); end
    tick();
    n_cmp++; if (done !== 4'b0100) begin n_err++; $display("FAIL single_done got=%b exp=0100", done); end
    n_cmp++; if (result !== 8'h30) begin n_err++; $display("FAIL single_result got=%h exp=30", result); end
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL single_grant_resp got=%b exp=0100", grant); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy2 got=%b exp=1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL single_done_end got=%b exp=0000", done); end
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_end got=%b exp=0000", grant); end
    n_cmp++; if (result !== 8'h30) begin n_err++; $display("FAIL single_result_hold got=%h exp=30", result); end
  endtask

  task automatic test_function_sweep();
    logic [7:0] exp_res [4] = '{8'h0A, 8'hAF, 8'hA5, 8'hF5};
    for (int k = 0; k < 4; k++) begin
      set_slot(1, 8'hAA, 8'h0F, 2'(k));
      req = 4'b0010;
      tick();
      req = '0;
      n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL sweep_grant op=%0d got=%b exp=0010", k, grant); end
      tick();
      n_cmp++; if (done !== 4'b0010) begin n_err++; $display("FAIL sweep_done op=%0d got=%b exp=0010", k, done); end
      n_cmp++; if (result !== exp_res[k]) begin n_err++; $display("FAIL sweep_result op=%0d got=%h exp=%h", k, result, exp_res[k]); end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [7:0] exp_r;
    apply_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 8'(8'h11 * (i + 1)), 8'hFF, 2'b00);
    req = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_r = 8'(8'h11 * ((k % 4) + 1));
      tick();
      n_cmp++; if (grant !== exp_g) begin n_err++; $display("FAIL fair_grant txn=%0d got=%b exp=%b", k, grant, exp_g); end
      n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL fair_done_early txn=%0d got=%b exp=0000", k, done); end
      tick();
      n_cmp++; if (done !== exp_g) begin n_err++; $display("FAIL fair_done txn=%0d got=%b exp=%b", k, done, exp_g); end
      n_cmp++; if (result !== exp_r) begin n_err++; $display("FAIL fair_result txn=%0d got=%h exp=%h", k, result, exp_r); end
      tick();
      n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL fair_idle_gap txn=%0d got=%b exp=0000", k, grant); end
    end
    req = '0;
    tick();
  endtask

  task automatic test_sampling_abort();
    set_slot(0, 8'h5A, 8'h0F, 2'b10);
    req = 4'b0001;
    tick();
    req = '0;
    set_slot(0, 8'hFF, 8'h00, 2'b11);
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL abort_grant got=%b exp=0001", grant); end
    tick();
    n_cmp++; if (done !== 4'b0001) begin n_err++; $display("FAIL abort_done got=%b exp=0001", done); end
    n_cmp++; if (result !== 8'h55) begin n_err++; $display("FAIL abort_result got=%h exp=55", result); end
    tick();
  endtask

  task automatic test_mid_reset();
    set_slot(2, 8'h0F, 8'hFF, 2'b01);
    req = 4'b0100;
    tick();
    n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL midrst_grant got=%b exp=0100", grant); end
    rst_n = 1'b0;
    req   = '0;
    tick();
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL midrst_grant0 got=%b exp=0000", grant); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL midrst_done0 got=%b exp=0000", done); end
    n_cmp++; if (result !== 8'h00) begin n_err++; $display("FAIL midrst_result got=%h exp=00", result); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    set_slot(3, 8'h3C, 8'hC3, 2'b01);
    req = 4'b1000;
    tick();
    req = '0;
    n_cmp++; if (grant !== 4'b1000) begin n_err++; $display("FAIL midrst_regrant got=%b exp=1000", grant); end
    n_cmp++; if (done !== 4'b0000) begin n_err++; $display("FAIL midrst_no_stale_done got=%b exp=0000", done); end
    tick();
    n_cmp++; if (done !== 4'b1000) begin n_err++; $display("FAIL midrst_done got=%b exp=1000", done); end
    n_cmp++; if (result !== 8'hFF) begin n_err++; $display("FAIL midrst_result2 got=%h exp=ff", result); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    op_a  = '0;
    op_b  = '0;
    opsel = '0;
    test_reset();
    test_single_op();
    test_function_sweep();
    test_fairness();
    test_sampling_abort();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
